// File: rtl/encoder4x2_rr_if.sv
// encoder4x2_rr_if: request/grant bus between a request source and the round-robin encoder
interface encoder4x2_rr_if;
  logic [3:0] D;
  logic       E;
  logic       R;
  logic [1:0] A;
  logic       V;
  logic [3:0] P;
  logic       OVF;
  modport master (output D, E, R, input A, V, P, OVF);
  modport slave  (input D, E, R, output A, V, P, OVF);
endinterface

// File: rtl/encoder4x2_rr.sv
// encoder4x2_rr: pending-mask 4-to-2 encoder with round-robin grant and valid/ready output
module encoder4x2_rr (
  input logic            clk,
  input logic            rst,
  encoder4x2_rr_if.slave bus
);
  typedef enum logic {IDLE, VALID} state_t;
  state_t     state_q, state_d;
  logic [1:0] a_q, a_d, ptr_q, ptr_d, sel, idx;
  logic [3:0] p_q, p_d, clr, set;
  logic       ovf_q, ovf_d, grant, found;
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && p_q[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    grant = |p_q && (state_q == IDLE || bus.R);
    clr = grant ? 4'b0001 << sel : 4'b0000;
    set = {4{bus.E}} & bus.D;
    // a set on the bit being granted re-arms it rather than merging
    p_d = (p_q & ~clr) | set;
    ovf_d = ovf_q | (|(set & p_q & ~clr));
    a_d = grant ? sel : a_q;
    ptr_d = grant ? sel : ptr_q;
    state_d = grant ? VALID : (bus.R ? IDLE : state_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= 2'b00;
      ptr_q <= 2'b11;
      p_q <= 4'b0000;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      ptr_q <= ptr_d;
      p_q <= p_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.A = a_q;
  assign bus.V = (state_q == VALID);
  assign bus.P = p_q;
  assign bus.OVF = ovf_q;
endmodule

// File: tb/tb_encoder4x2_rr.sv
// tb_encoder4x2_rr: directed and random stimulus against a queue-based reference model
module tb_encoder4x2_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  encoder4x2_rr_if bus ();
  encoder4x2_rr dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [3:0] mp = 4'b0;
  int mptr = 3;
  bit mbusy = 0;
  bit movf = 0;
  int ma = 0;
  int exp_q[$];
  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  // reference: pending set of codes, next grant found by scanning from ptr+1 upward mod 4
  task automatic model(input logic r_st, input logic [3:0] d, input logic e, input logic r);
    int g;
    g = -1;
    if (r_st) begin
      mp = 4'b0; mptr = 3; mbusy = 0; movf = 0; ma = 0;
      exp_q.delete();
    end else begin
      if (mp != 0 && (!mbusy || r))
        for (int k = 1; k <= 4; k++)
          if (g < 0 && mp[(mptr + k) % 4]) g = (mptr + k) % 4;
      if (g >= 0) begin
        mp[g] = 1'b0; mptr = g; ma = g; mbusy = 1;
        exp_q.push_back(g);
      end else if (mbusy && r) mbusy = 0;
      for (int i = 0; i < 4; i++)
        if (e && d[i]) begin
          if (mp[i]) movf = 1;
          mp[i] = 1'b1;
        end
    end
  endtask
  task automatic step(input logic r_st, input logic [3:0] d, input logic e, input logic r);
    rst = r_st; bus.D = d; bus.E = e; bus.R = r;
    @(posedge clk);
    model(r_st, d, e, r);
    started = 1;
    #2;
  endtask
  initial begin : monitor
    bit pv, phs;
    int got;
    pv = 0; phs = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("P", bus.P, mp);
        chk("V", {3'b0, bus.V}, {3'b0, mbusy});
        chk("A", {2'b0, bus.A}, 4'(ma));
        chk("OVF", {3'b0, bus.OVF}, {3'b0, movf});
        if (bus.V && (!pv || phs)) begin
          if (exp_q.size() == 0) chk("sb_empty", 4'd1, 4'd0);
          else begin
            got = exp_q.pop_front();
            chk("sb_code", {2'b0, bus.A}, 4'(got));
          end
        end
        pv = bus.V;
        phs = bus.V && bus.R && !rst;
      end
    end
  end
  initial begin
    bus.D = 4'b0; bus.E = 1'b0; bus.R = 1'b0;
    #1;
    step(1, 0, 0, 1);
    step(1, 4'b1111, 1, 1);
    step(0, 4'b0100, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 4'b1111, 1, 1);
    repeat (5) step(0, 0, 1, 1);
    step(0, 4'b0011, 1, 0);
    repeat (6) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 4'b0010, 1, 0);
    step(0, 4'b0010, 1, 0);
    repeat (2) step(0, 4'b0010, 1, 0);
    repeat (4) step(0, 0, 0, 1);
    repeat (3) step(0, 4'b1000, 0, 1);
    step(1, 0, 0, 0);
    step(0, 4'b0100, 1, 1);
    step(0, 4'b1001, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 4'b0110, 1, 0);
    step(0, 4'b1001, 1, 1);
    repeat (4) step(0, 0, 0, 1);
    for (int n = 0; n < 1500; n++)
      step(($urandom_range(63) == 0), 4'($urandom), ($urandom_range(3) != 0), ($urandom_range(9) < 6));
    repeat (10) step(0, 0, 0, 1);
    @(negedge clk);
    chk("sb_drained", 4'(exp_q.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
